wb_sdram_arbiter: RTL
=====================

# wb_sdram_arbiter

Two-master Wishbone arbiter in front of the SDRAM controller's single Wishbone slave port, in the `wb_clk_i` domain. It holds off all traffic until the controller reports `sdr_init_done`, then grants masters round-robin. A grant is held for the whole `cyc` of the owner. A watchdog terminates any access the controller fails to acknowledge within a bounded time.

## Interface
Parameters:
- `APP_AW`, 26: Wishbone address width.
- `DW`, 32: data width. Byte-select width is `DW/8`.
- `TIMEOUT`, 255: maximum cycles a strobe may wait for `ack`. Legal range 2..65535.

Ports (`mN` means `m0` and `m1`, identical sets):
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `sdr_init_done`  in  1  from the SDRAM clock domain; synchronized internally.
- `mN_cyc_i`, `mN_stb_i`, `mN_we_i`  in  1 each.
- `mN_sel_i`  in  DW/8.
- `mN_adr_i`  in  APP_AW.
- `mN_dat_i`  in  DW.
- `mN_dat_o`  out  DW.
- `mN_ack_o`, `mN_err_o`  out  1 each.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each, to the controller.
- `s_sel_o`  out  DW/8.
- `s_adr_o`  out  APP_AW.
- `s_dat_o`  out  DW.
- `s_dat_i`  in  DW.
- `s_ack_i`  in  1.

## Operation
- FSM states: `IDLE`, `BUSY`, `ERR`, `DRAIN`.
- `init_ok` is `sdr_init_done` after a 2-flop synchronizer. In `IDLE`, no grant is made while `init_ok`=0.
- **IDLE:** a request is `mN_cyc_i & mN_stb_i`.
  - One requester: grant it and go to `BUSY`.
  - Both requesting: grant the master that is not `last_grant`.
  - `last_grant` resets to 1, so `m0` wins the first tie.
- **BUSY:**
  - Slave `cyc`/`stb`/`we`/`sel`/`adr`/`dat` mirror the owner.
  - `s_dat_i` is routed to the owner's `dat_o`.
  - `s_ack_i` is routed to the owner's `ack_o`, gated by the owner's `stb`.
  - The non-owner sees `ack_o`=0, `err_o`=0 and `dat_o`=0.
  - When the owner drops `cyc_i`: go to `IDLE` and set `last_grant` to the owner.
- **Watchdog:** a 16-bit counter.
  - Cleared on `s_ack_i`, and whenever the owner's `stb` is low.
  - Increments while the owner's `stb` is high without `ack`.
  - When the counter equals `TIMEOUT-1` with no `ack`, go to `ERR`.
- **ERR:** one cycle. Owner's `err_o`=1, `s_cyc_o`=`s_stb_o`=0. Then go to `DRAIN`.
- **DRAIN:**
  - Slave signals stay 0.
  - Any late `s_ack_i` is discarded.
  - When the owner drops `cyc_i`: go to `IDLE` and update `last_grant`.
- **`init_ok` falls during `BUSY`:** the current cycle still completes. No new grants are made.
- **Reset:** asynchronous and allowed at any time, including mid-cycle. State returns to `IDLE`, all outputs go to 0, the counter clears, and the synchronizer flops clear.

## Timing
- **Grant latency:** with `init_ok` high, request sampled in `IDLE` at edge k gives `s_cyc_o`/`s_stb_o` high after edge k (registered grant). The slave-side mux is combinational from the registered owner.
- **`ack`/data path:** combinational from `s_ack_i`/`s_dat_i` to the owner, zero added cycles.
- **Ownership change:** owner `cyc_i` low sampled at edge k gives `IDLE` after k. The next owner's `s_cyc_o` rises after edge k+1. There is at least one dead cycle between owners.
- **`err_o`:** asserted exactly one cycle, TIMEOUT edges after `stb` became active without `ack`.
- **`sdr_init_done` rise to first possible grant:** 2 synchronizer cycles + 1 grant cycle.

## Structure
- Package `wb_sdram_arb_pkg` holds:
  - the state enum (`IDLE`, `BUSY`, `ERR`, `DRAIN`);
  - the owner index type (1 bit);
  - the watchdog counter width constant (16).
- Sub-module `sync_2ff` is the synchronizer for `sdr_init_done`, with an asynchronous clear on `wb_rst_i`.
- The arbiter FSM, watchdog and muxes live in the top module.

## Test plan
- **Init gating:** hold `sdr_init_done`=0, assert `m0` write to `adr` 0x10 → `s_cyc_o` stays 0. Raise `sdr_init_done` → `s_cyc_o` rises 3 cycles later.
- **Tie and round-robin:** after init, both masters request in the same cycle → `m0` granted first. `m0` releases → `m1` granted after 1 dead cycle. Both request again → `m1` loses to `m0`? No: `last_grant`=`m1`, so `m0` wins.
- **Single read routing:** `m1` reads 0x20, slave returns `ack` with 0xDEADBEEF → `m1_dat_o`=0xDEADBEEF and `m1_ack_o`=1 in the same cycle. `m0_ack_o` and `m0_dat_o` stay 0.
- **Multi-beat hold:** `m0` keeps `cyc` for 4 acked strobes while `m1` requests → `m1` is not granted until `m0` `cyc` falls.
- **Timeout:** `TIMEOUT`=8, slave never acks `m0` → `m0_err_o` pulses one cycle 8 edges after the strobe, and `s_cyc_o` drops. A late `s_ack_i` in `DRAIN` is not forwarded. After `m0` drops `cyc`, `m1` is granted.
- **Reset mid-cycle:** assert `wb_rst_i` during `BUSY` between edges → all outputs 0 immediately. After release, the first tie goes to `m0`.

Source files
------------

// File: rtl/wb_sdram_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter that fronts the SDRAM
// controller's single slave port.
//   arb_state_e : arbiter FSM states
//   owner_t     : index of the master holding the grant (0 = m0, 1 = m1)
//   WD_W        : width of the ack watchdog counter
package wb_sdram_arb_pkg;

    localparam int WD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERR   = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    typedef logic owner_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal arriving from another
// clock domain.
//   clk : destination clock
//   rst : asynchronous active-high clear of both flops
//   d   : asynchronous input level
//   q   : synchronized level, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;

    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller slave port.
// Grants nothing until the controller reports init done, then grants
// round-robin and holds the grant for the owner's whole cycle. A watchdog
// ends any strobe the controller leaves unacknowledged for TIMEOUT cycles
// with a one-cycle err_o to the owner.
//   wb_clk_i, wb_rst_i    : clock, async active-high reset
//   sdr_init_done         : controller init status (other clock domain)
//   mN_*_i / mN_*_o       : master-side Wishbone ports (m0, m1)
//   s_*_o / s_dat_i/ack_i : slave-side Wishbone port to the controller
module wb_sdram_arbiter
    import wb_sdram_arb_pkg::*;
#(
    parameter int APP_AW  = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [APP_AW-1:0] m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [APP_AW-1:0] m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [APP_AW-1:0] s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i
);

    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    owner_t          owner_q, owner_d;
    owner_t          last_grant_q, last_grant_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic init_ok;
    logic req0, req1;
    logic own_cyc, own_stb;
    logic ack_fwd;

    sync_2ff u_init_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (sdr_init_done),
        .q   (init_ok)
    );

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner_q ? m1_stb_i : m0_stb_i;

    // Next-state: grant, release and watchdog.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                // init_ok only gates new grants; a cycle already in
                // progress is allowed to finish if it drops.
                if (init_ok && (req0 || req1)) begin
                    state_d = BUSY;
                    owner_d = (req0 && req1) ? ~last_grant_q : owner_t'(req1);
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                    wd_d         = '0;
                end else if (s_ack_i || !own_stb) begin
                    wd_d = '0;
                end else if (wd_q == WD_LIMIT) begin
                    state_d = ERR;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ERR: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!own_cyc) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;   // m0 wins the first tie
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
        end
    end

    // Output muxes: combinational from the registered state/owner so the
    // ack and read data reach the owner with no added latency. Everything
    // outside BUSY/ERR is forced to zero, which also makes all outputs drop
    // the moment reset asserts.
    assign ack_fwd = s_ack_i & own_stb;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            BUSY: begin
                s_cyc_o = own_cyc;
                s_stb_o = own_stb;
                if (owner_q) begin
                    s_we_o   = m1_we_i;
                    s_sel_o  = m1_sel_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    m1_dat_o = s_dat_i;
                    m1_ack_o = ack_fwd;
                end else begin
                    s_we_o   = m0_we_i;
                    s_sel_o  = m0_sel_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    m0_dat_o = s_dat_i;
                    m0_ack_o = ack_fwd;
                end
            end
            ERR: begin
                if (owner_q) m1_err_o = 1'b1;
                else         m0_err_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
